// File: rtl/pe_row_pkg.sv
// Shared types and defaults for the PE row sequencer.
package pe_row_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam int PE_N_DEF  = 4;
  localparam int PE_DW_DEF = 16;
  localparam int PE_KW_DEF = 8;

  // Extracts lane j of a packed per-PE bus at the default geometry.
  function automatic logic [PE_DW_DEF-1:0] lane_slice(
    input logic [PE_N_DEF*PE_DW_DEF-1:0] bus,
    input int                            lane
  );
    return bus[lane*PE_DW_DEF +: PE_DW_DEF];
  endfunction

endpackage

// File: rtl/pe_row_skew.sv
// Per-lane operand skew: lane j is delayed by j+1 registers so the top operand
// meets the left operand as it ripples one PE per cycle along the row.
module pe_row_skew
  import pe_row_pkg::*;
#(
  parameter int N_PE = PE_N_DEF,
  parameter int DW   = PE_DW_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [N_PE*DW-1:0] din,
  output logic [N_PE*DW-1:0] dout
);

  for (genvar j = 0; j < N_PE; j++) begin : g_lane
    logic [DW-1:0] line_q [0:j];

    // Shift register of depth j+1; cleared together with the PE row.
    always_ff @(posedge clk) begin
      if (clear) begin
        for (int k = 0; k <= j; k++) line_q[k] <= '0;
      end else begin
        line_q[0] <= din[j*DW +: DW];
        for (int k = 1; k <= j; k++) line_q[k] <= line_q[k-1];
      end
    end

    assign dout[j*DW +: DW] = line_q[j];
  end

endmodule

// File: rtl/pe_row_ctrl.sv
// Sequencer for one row of MAC PEs: clear, skewed feed, flush, then a
// credit-limited drain into a 2-entry result FIFO with valid/ready output.
module pe_row_ctrl
  import pe_row_pkg::*;
#(
  parameter int N_PE = PE_N_DEF,
  parameter int DW   = PE_DW_DEF,
  parameter int KW   = PE_KW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_a,
  input  logic [N_PE*DW-1:0] in_t,
  output logic               pe_reset,
  output logic               pe_read,
  output logic [DW-1:0]      pe_l_d,
  output logic [N_PE*DW-1:0] pe_t_d,
  input  logic [DW-1:0]      pe_drain_i,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW-1:0]      res_data,
  output logic               res_last
);

  localparam int CW = $clog2(N_PE + 1);
  localparam logic [CW-1:0] N_PE_C = CW'(N_PE);

  state_e        state_q, state_d;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] beat_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] reads_issued;
  logic [CW-1:0] pop_cnt;
  logic          read_q;

  logic [DW-1:0] fifo_mem [0:1];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_count;

  logic          accept;
  logic          push;
  logic          pop;
  logic [2:0]    occ;
  logic [N_PE*DW-1:0] skew_din;

  assign accept    = in_valid && in_ready;
  assign push      = read_q;
  assign res_valid = (fifo_count != 2'd0);
  assign pop       = res_valid && res_ready;
  assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;
  assign res_last  = res_valid && (pop_cnt == N_PE_C - CW'(1));
  assign occ       = {1'b0, fifo_count} + {2'b00, read_q};
  assign pe_reset  = reset || (state_q == CLEAR);
  assign skew_din  = accept ? in_t : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control outputs; drain reads only while the FIFO plus the
  // word still in flight from the PEs leaves room, counting a same-cycle pop.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    in_ready = 1'b0;
    pe_read  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = (k_reg != '0) ? FEED : DRAIN;
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == k_reg - KW'(1))) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == N_PE_C - CW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        pe_read = (reads_issued < N_PE_C) && (occ < (3'd2 + {2'b00, pop}));
        if (pop && res_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job counters: beats accepted, flush cycles, drain reads, results popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg        <= '0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
      reads_issued <= '0;
      pop_cnt      <= '0;
      read_q       <= 1'b0;
    end else begin
      read_q <= pe_read;
      if ((state_q == IDLE) && start) k_reg <= k_len;
      if (state_q == CLEAR) begin
        beat_cnt     <= '0;
        flush_cnt    <= '0;
        reads_issued <= '0;
        pop_cnt      <= '0;
      end else begin
        if (accept)             beat_cnt     <= beat_cnt + KW'(1);
        if (state_q == FLUSH)   flush_cnt    <= flush_cnt + CW'(1);
        if (pe_read)            reads_issued <= reads_issued + CW'(1);
        if (pop)                pop_cnt      <= pop_cnt + CW'(1);
      end
    end
  end

  // Left operand stage: accepted beat or zero bubble into PE0.
  always_ff @(posedge clk) begin
    if (pe_reset) pe_l_d <= '0;
    else          pe_l_d <= accept ? in_a : '0;
  end

  pe_row_skew #(
    .N_PE (N_PE),
    .DW   (DW)
  ) u_skew (
    .clk   (clk),
    .clear (pe_reset),
    .din   (skew_din),
    .dout  (pe_t_d)
  );

  // Result FIFO pointers and occupancy; PE0 output lands one cycle after a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pe_drain_i;
  end

endmodule

// File: doc/pe_row_ctrl.md
Name: pe_row_ctrl

Overview:
- Sequencer for one row of N_PE multiply-accumulate PEs chained left-to-right.
- Operands move one PE per cycle along the row. In drain mode, accumulators shift right-to-left and leave through PE0's left output.
- The block clears the row, feeds K operand beats with per-lane skew, flushes the pipeline, then drains N_PE results through a valid/ready output with backpressure.
- It sits between the operand source (upstream valid/ready) and the result consumer.

Parameters:
- N_PE, 4, number of PEs in the row.
- DW, 16, data width of operands and results.
- KW, 8, width of the k_len beat count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle job request; sampled only in IDLE.
- k_len  in  KW  number of operand beats for the job; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the cycle the last result is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- in_a  in  DW  shared left operand.
- in_t  in  N_PE*DW  per-PE top operands; lane j is bits [j*DW +: DW].
- pe_reset  out  1  PE reset; equals reset OR (state == CLEAR).
- pe_read  out  1  PE drain-shift enable.
- pe_l_d  out  DW  drives PE0 left data input.
- pe_t_d  out  N_PE*DW  drives the PE top inputs, lane j to PE j.
- pe_drain_i  in  DW  PE0 left data output.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_data  out  DW  result; word i is PE i's accumulator.
- res_last  out  1  high with the N_PE-th result.

Behaviour:
- Reset:
  - state = IDLE; all outputs 0 except pe_reset = 1.
  - Skew registers and result FIFO are cleared.
  - Reset mid-job abandons the job; no done pulse, no further results.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE:
  - start latches k_len and moves to CLEAR.
  - start while busy is ignored.
- CLEAR:
  - Lasts one cycle with pe_reset = 1.
  - Next state is FEED if k_len != 0, otherwise DRAIN.
- FEED:
  - in_ready = 1.
  - Each accepted beat registers in_a onto pe_l_d.
  - Lane j of in_t enters a skew line of j+1 registers feeding pe_t_d lane j.
  - A cycle with no accepted beat injects a = 0 and t = 0 for all lanes; bubbles are harmless.
  - After the k_len-th acceptance, go to FLUSH.
- FLUSH:
  - Exactly N_PE cycles of zero injection, so the last beat reaches PE N_PE-1 before draining.
- DRAIN:
  - pe_l_d = 0; zero injection continues.
  - pe_read is asserted in a cycle only when reads_issued < N_PE and (fifo_count + inflight) < 2. Here inflight = 1 if pe_read was high in the previous cycle; a pop in the current cycle counts as freeing space.
  - pe_drain_i is pushed into the 2-entry result FIFO in the cycle after each pe_read cycle.
  - res_valid = FIFO not empty; res_data = FIFO head; pop on res_valid && res_ready.
  - res_last is high when the head is the N_PE-th word.
  - On acceptance of the last word: done = 1 for one cycle and state goes to IDLE.
  - With pe_read low, the PEs hold their values (zero operands), so stalls lose nothing.
- Latency:
  - First pe_read occurs at the earliest N_PE+1 cycles after the last FEED acceptance.
  - First res_valid occurs 2 cycles after the first pe_read.
- Arithmetic: none in this block. PE products and sums wrap modulo 2^DW; the controller passes values unmodified.
- The rightmost PE's right data input is tied to 0 by the array wrapper, not driven by this block.

Decomposition:
- Package pe_row_pkg:
  - state enum state_e {IDLE, CLEAR, FEED, FLUSH, DRAIN}.
  - Default constants for DW, N_PE, KW.
  - Lane slice helper function.
- Sub-module: pe_row_skew (generate-based per-lane delay lines, lane j depth j+1, synchronous clear).
- The 2-entry FIFO and credit logic stay inline.

Test Plan:
1. N_PE=4, k_len=1, a=2, t={1,2,3,4}, res_ready=1 -> results 2,4,6,8; res_last on 8; done pulses once; busy drops the next cycle.
2. k_len=3, a=1,2,3, lane j t=j+1 every beat -> results 6,12,18,24.
3. Same as 2 with in_valid low 2 cycles between beats -> identical results; in_ready high only in FEED.
4. Same as 2 with res_ready low for 5 cycles after the first res_valid -> no loss or reorder; pe_read low while FIFO+inflight=2; results 6,12,18,24.
5. k_len=0 -> CLEAR then DRAIN directly; results 0,0,0,0 with res_last on the 4th.
6. Reset asserted mid-FEED, then a new job as in scenario 1 -> results 2,4,6,8, no residue from the old job. Also run a=256, t=256, k_len=1 -> all results 0 (wrap).
